fetch_unit: RTL and testbench

- Fetch stage directly upstream of instruction_memory and downstream of nothing but the control path.
- Owns the program counter, drives the 4-bit instruction memory address, and strobes IR_enable.
- Latches the returned 16-bit word into an instruction register, then presents it to decode with a valid/ready handshake.
- Accepts redirects (branch/jump targets) from execute and flushes the held instruction.

---
 rtl/fetch_unit_if.sv | 50 +++++
 rtl/fetch_unit.sv | 99 +++++++++
 tb/tb_fetch_unit.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: instruction memory port, decode handshake, redirect and status.
// Parameters must match the fetch_unit instance that uses the master modport.
interface fetch_unit_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
);
    logic              run;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_instr;
    logic              ir_enable;
    logic [DATA_W-1:0] ir;
    logic [ADDR_W-1:0] ir_pc;
    logic              ir_valid;
    logic              ir_ready;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;
    logic [1:0]        state;
    logic [CNT_W-1:0]  fetch_count;

    modport master (
        input  run,
        output imem_addr,
        input  imem_instr,
        output ir_enable,
        output ir,
        output ir_pc,
        output ir_valid,
        input  ir_ready,
        input  redirect_valid,
        input  redirect_addr,
        output state,
        output fetch_count
    );

    modport slave (
        output run,
        input  imem_addr,
        output imem_instr,
        input  ir_enable,
        input  ir,
        input  ir_pc,
        input  ir_valid,
        output ir_ready,
        output redirect_valid,
        output redirect_addr,
        input  state,
        input  fetch_count
    );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: PC, instruction register and decode handshake with redirect/flush.
// Optional macro FETCH_JUMP_PREDECODE_EN follows 4'b1011 jump words at capture.
module fetch_unit #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {
        ST_START = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir;
    logic [ADDR_W-1:0] r_ir_pc;
    logic              r_ir_valid;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_free;
    logic              w_cap;
    logic              w_hs;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_next_pc;

    assign w_free   = !r_ir_valid || bus.ir_ready;
    assign w_hs     = r_ir_valid && bus.ir_ready;
    assign w_cap    = (r_state == ST_RUN) && bus.run && w_free
                      && !bus.redirect_valid;
    assign w_pc_inc = r_pc + ADDR_W'(1);

`ifdef FETCH_JUMP_PREDECODE_EN
    logic w_is_jump;
    assign w_is_jump = (bus.imem_instr[DATA_W-1:DATA_W-4] == 4'b1011);
    assign w_next_pc = w_is_jump ? bus.imem_instr[ADDR_W-1:0] : w_pc_inc;
`else
    assign w_next_pc = w_pc_inc;
`endif

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_START: w_state_nxt = ST_RUN;
            ST_RUN:   w_state_nxt = bus.run ? ST_RUN : ST_PAUSE;
            ST_PAUSE: w_state_nxt = bus.run ? ST_RUN : ST_PAUSE;
            default:  w_state_nxt = ST_START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_START;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Redirect beats capture; a handshake in the same cycle still retires.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= '0;
            r_ir       <= '0;
            r_ir_pc    <= '0;
            r_ir_valid <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if (w_hs) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (bus.redirect_valid) begin
                r_pc       <= bus.redirect_addr;
                r_ir_valid <= 1'b0;
            end else if (w_cap) begin
                r_ir       <= bus.imem_instr;
                r_ir_pc    <= r_pc;
                r_ir_valid <= 1'b1;
                r_pc       <= w_next_pc;
            end else if (w_hs) begin
                r_ir_valid <= 1'b0;
            end
        end
    end

    assign bus.imem_addr   = r_pc;
    assign bus.ir_enable   = w_cap && !reset;
    assign bus.ir          = r_ir;
    assign bus.ir_pc       = r_ir_pc;
    assign bus.ir_valid    = r_ir_valid;
    assign bus.state       = r_state;
    assign bus.fetch_count = r_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stream, stall, redirect, pause, reset, jump.
// Memory holds k*0x1111 at address k unless a test overrides a word.
module tb_fetch_unit;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic [15:0] mem [16];

    fetch_unit_if #(.ADDR_W(4), .DATA_W(16), .CNT_W(8)) bus ();

    fetch_unit #(.ADDR_W(4), .DATA_W(16), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.imem_instr = mem[bus.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset, then stream with ready=1 until ir holds address n.
    task automatic run_to(input int n);
        reset              = 1'b1;
        bus.run            = 1'b1;
        bus.ir_ready       = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = 4'd0;
        step();
        reset = 1'b0;
        repeat (n + 2) step();
    endtask

    task automatic test_reset();
        reset              = 1'b1;
        bus.run            = 1'b1;
        bus.ir_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = 4'd0;
        step();
        step();
        checks++;
        if (bus.ir !== 16'h0 || bus.ir_pc !== 4'd0 || bus.ir_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_ir got ir=%h pc=%0d v=%b want 0 0 0",
                     bus.ir, bus.ir_pc, bus.ir_valid);
        end
        checks++;
        if (bus.fetch_count !== 8'd0 || bus.state !== 2'b00 || bus.imem_addr !== 4'd0) begin
            failures++;
            $display("FAIL reset_state got cnt=%0d st=%b pc=%0d want 0 00 0",
                     bus.fetch_count, bus.state, bus.imem_addr);
        end
        checks++;
        if (bus.ir_enable !== 1'b0) begin
            failures++;
            $display("FAIL reset_ir_enable got %b want 0", bus.ir_enable);
        end
    endtask

    task automatic test_stream();
        logic [3:0] ep;
        reset        = 1'b0;
        bus.run      = 1'b1;
        bus.ir_ready = 1'b1;
        step();
        checks++;
        if (bus.state !== 2'b01 || bus.ir_valid !== 1'b0 || bus.ir_enable !== 1'b1) begin
            failures++;
            $display("FAIL stream_start got st=%b v=%b en=%b want 01 0 1",
                     bus.state, bus.ir_valid, bus.ir_enable);
        end
        for (int k = 0; k < 18; k++) begin
            step();
            ep = 4'(k);
            checks++;
            if (bus.ir_pc !== ep || bus.ir !== 16'(ep) * 16'h1111
                || bus.ir_valid !== 1'b1) begin
                failures++;
                $display("FAIL stream_ir k=%0d got pc=%0d ir=%h v=%b want pc=%0d ir=%h v=1",
                         k, bus.ir_pc, bus.ir, bus.ir_valid, ep, 16'(ep) * 16'h1111);
            end
            checks++;
            if (bus.fetch_count !== 8'(k) || bus.ir_enable !== 1'b1
                || bus.imem_addr !== ep + 4'd1) begin
                failures++;
                $display("FAIL stream_cnt k=%0d got cnt=%0d en=%b pc=%0d want %0d 1 %0d",
                         k, bus.fetch_count, bus.ir_enable, bus.imem_addr, k, ep + 4'd1);
            end
        end
    endtask

    task automatic test_stall();
        run_to(4);
        bus.ir_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.ir_pc !== 4'd4 || bus.ir !== 16'h4444 || bus.ir_valid !== 1'b1
                || bus.imem_addr !== 4'd5 || bus.ir_enable !== 1'b0
                || bus.fetch_count !== 8'd4) begin
                failures++;
                $display("FAIL stall_hold k=%0d got irpc=%0d ir=%h v=%b pc=%0d en=%b cnt=%0d want 4 4444 1 5 0 4",
                         k, bus.ir_pc, bus.ir, bus.ir_valid, bus.imem_addr,
                         bus.ir_enable, bus.fetch_count);
            end
            step();
        end
        bus.ir_ready = 1'b1;
        #1;
        checks++;
        if (bus.ir_enable !== 1'b1 || bus.ir_pc !== 4'd4) begin
            failures++;
            $display("FAIL stall_release got en=%b irpc=%0d want 1 4",
                     bus.ir_enable, bus.ir_pc);
        end
        step();
        checks++;
        if (bus.ir_pc !== 4'd5 || bus.fetch_count !== 8'd5 || bus.ir !== 16'h5555) begin
            failures++;
            $display("FAIL stall_next got irpc=%0d cnt=%0d ir=%h want 5 5 5555",
                     bus.ir_pc, bus.fetch_count, bus.ir);
        end
        step();
        checks++;
        if (bus.ir_pc !== 4'd6 || bus.fetch_count !== 8'd6) begin
            failures++;
            $display("FAIL stall_after got irpc=%0d cnt=%0d want 6 6",
                     bus.ir_pc, bus.fetch_count);
        end
    endtask

    task automatic test_redirect();
        run_to(6);
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 4'd2;
        #1;
        checks++;
        if (bus.ir_enable !== 1'b0) begin
            failures++;
            $display("FAIL redir_no_cap got en=%b want 0", bus.ir_enable);
        end
        step();
        bus.redirect_valid = 1'b0;
        checks++;
        if (bus.ir_valid !== 1'b0 || bus.imem_addr !== 4'd2 || bus.fetch_count !== 8'd7) begin
            failures++;
            $display("FAIL redir_flush got v=%b pc=%0d cnt=%0d want 0 2 7",
                     bus.ir_valid, bus.imem_addr, bus.fetch_count);
        end
        step();
        checks++;
        if (bus.ir_pc !== 4'd2 || bus.ir !== 16'h2222 || bus.ir_valid !== 1'b1
            || bus.fetch_count !== 8'd7) begin
            failures++;
            $display("FAIL redir_resume got irpc=%0d ir=%h v=%b cnt=%0d want 2 2222 1 7",
                     bus.ir_pc, bus.ir, bus.ir_valid, bus.fetch_count);
        end
    endtask

    task automatic test_pause();
        run_to(2);
        bus.run = 1'b0;
        #1;
        checks++;
        if (bus.ir_enable !== 1'b0 || bus.imem_addr !== 4'd3) begin
            failures++;
            $display("FAIL pause_enter got en=%b pc=%0d want 0 3",
                     bus.ir_enable, bus.imem_addr);
        end
        step();
        checks++;
        if (bus.state !== 2'b10 || bus.ir_valid !== 1'b0 || bus.imem_addr !== 4'd3
            || bus.fetch_count !== 8'd3) begin
            failures++;
            $display("FAIL pause_drain got st=%b v=%b pc=%0d cnt=%0d want 10 0 3 3",
                     bus.state, bus.ir_valid, bus.imem_addr, bus.fetch_count);
        end
        step();
        bus.run = 1'b1;
        #1;
        checks++;
        if (bus.state !== 2'b10 || bus.imem_addr !== 4'd3 || bus.ir_enable !== 1'b0) begin
            failures++;
            $display("FAIL pause_hold got st=%b pc=%0d en=%b want 10 3 0",
                     bus.state, bus.imem_addr, bus.ir_enable);
        end
        step();
        checks++;
        if (bus.state !== 2'b01 || bus.ir_valid !== 1'b0 || bus.ir_enable !== 1'b1) begin
            failures++;
            $display("FAIL pause_resume got st=%b v=%b en=%b want 01 0 1",
                     bus.state, bus.ir_valid, bus.ir_enable);
        end
        step();
        checks++;
        if (bus.ir_pc !== 4'd3 || bus.ir !== 16'h3333 || bus.ir_valid !== 1'b1) begin
            failures++;
            $display("FAIL pause_first got irpc=%0d ir=%h v=%b want 3 3333 1",
                     bus.ir_pc, bus.ir, bus.ir_valid);
        end
    endtask

    task automatic test_reset_mid();
        run_to(8);
        reset = 1'b1;
        #1;
        checks++;
        if (bus.ir_enable !== 1'b0 || bus.imem_addr !== 4'd9 || bus.ir_valid !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre got en=%b pc=%0d v=%b want 0 9 1",
                     bus.ir_enable, bus.imem_addr, bus.ir_valid);
        end
        step();
        reset = 1'b0;
        checks++;
        if (bus.ir !== 16'h0 || bus.ir_pc !== 4'd0 || bus.ir_valid !== 1'b0
            || bus.imem_addr !== 4'd0 || bus.state !== 2'b00
            || bus.fetch_count !== 8'd0) begin
            failures++;
            $display("FAIL rstmid_clear got ir=%h irpc=%0d v=%b pc=%0d st=%b cnt=%0d want all 0",
                     bus.ir, bus.ir_pc, bus.ir_valid, bus.imem_addr,
                     bus.state, bus.fetch_count);
        end
        step();
        step();
        checks++;
        if (bus.ir_pc !== 4'd0 || bus.ir_valid !== 1'b1 || bus.imem_addr !== 4'd1) begin
            failures++;
            $display("FAIL rstmid_first got irpc=%0d v=%b pc=%0d want 0 1 1",
                     bus.ir_pc, bus.ir_valid, bus.imem_addr);
        end
    endtask

    task automatic test_jump();
        logic [3:0] exp_pc;
`ifdef FETCH_JUMP_PREDECODE_EN
        exp_pc = 4'd0;
`else
        exp_pc = 4'd8;
`endif
        mem[7] = 16'hB000;
        run_to(6);
        step();
        checks++;
        if (bus.ir !== 16'hB000 || bus.ir_pc !== 4'd7 || bus.imem_addr !== exp_pc) begin
            failures++;
            $display("FAIL jump got ir=%h irpc=%0d pc=%0d want b000 7 %0d",
                     bus.ir, bus.ir_pc, bus.imem_addr, exp_pc);
        end
        mem[7] = 16'h7777;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int k = 0; k < 16; k++) mem[k] = 16'(k) * 16'h1111;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_pause();
        test_reset_mid();
        test_jump();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
